// File: rtl/instruction_cache_if.sv
// Fetch port bundle: the requester drives address and request, the cache
// returns the registered hit flag and instruction word.
interface instruction_cache_if;
    logic [31:0] addr;
    logic        fetch_req;
    logic [63:0] data_out;
    logic        hit;

    modport master (
        output addr,
        output fetch_req,
        input  data_out,
        input  hit
    );

    modport slave (
        input  addr,
        input  fetch_req,
        output data_out,
        output hit
    );
endinterface

// File: rtl/instruction_cache.sv
// 2-way set-associative instruction cache, 64 sets of 32-byte lines, filled in a
// single cycle from an internal combinational backing store ({A, ~A} per word).
module instruction_cache (
    input  logic                clk,
    input  logic                rst,
    instruction_cache_if.slave  bus
);
    localparam int WAYS   = 2;
    localparam int SETS   = 64;
    localparam int WORDS  = 4;
    localparam int TAG_W  = 21;
    localparam int LINE_W = 64 * WORDS;

    logic [1:0]       word_sel;
    logic [5:0]       index;
    logic [TAG_W-1:0] tag;
    logic             unused_addr_bits;

    assign word_sel         = bus.addr[4:3];
    assign index            = bus.addr[10:5];
    assign tag              = bus.addr[31:11];
    assign unused_addr_bits = ^bus.addr[2:0];

    // Tag and line storage carry no reset; validity lives in valid_reg.
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [LINE_W-1:0] line_mem [WAYS][SETS];

    logic [WAYS-1:0][SETS-1:0] valid_reg;
    logic [SETS-1:0]           lru_reg;
    logic                      hit_reg;
    logic [63:0]               data_reg;

    logic [WAYS-1:0]   way_match;
    logic [63:0]       way_word [WAYS];
    logic [LINE_W-1:0] fill_line;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            assign way_match[gi] = valid_reg[gi][index] && (tag_mem[gi][index] == tag);
            assign way_word[gi]  = line_mem[gi][index][{word_sel, 6'b0} +: 64];
        end
        for (gi = 0; gi < WORDS; gi++) begin : g_fill
            logic [31:0] word_addr;
            assign word_addr = {bus.addr[31:5], 2'(gi), 3'b000};
            assign fill_line[gi*64 +: 64] = {word_addr, ~word_addr};
        end
    endgenerate

    logic lookup_hit;
    logic hit_way;
    logic victim_way;
    logic used_way;

    always_comb begin
        lookup_hit = |way_match;
        // Way 0 wins if both ever match.
        hit_way    = way_match[0] ? 1'b0 : 1'b1;
        victim_way = lru_reg[index];
        if (!valid_reg[0][index]) begin
            victim_way = 1'b0;
        end else if (!valid_reg[1][index]) begin
            victim_way = 1'b1;
        end
        used_way = lookup_hit ? hit_way : victim_way;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= '0;
            lru_reg   <= '0;
            hit_reg   <= 1'b0;
            data_reg  <= 64'h0;
        end else if (bus.fetch_req) begin
            hit_reg        <= lookup_hit;
            data_reg       <= lookup_hit ? way_word[hit_way]
                                         : fill_line[{word_sel, 6'b0} +: 64];
            lru_reg[index] <= ~used_way;
            if (!lookup_hit) begin
                valid_reg[victim_way][index] <= 1'b1;
            end
        end
    end

    // A write landing during reset is harmless: the entry stays invalid.
    always_ff @(posedge clk) begin
        if (bus.fetch_req && !lookup_hit) begin
            tag_mem[victim_way][index]  <= tag;
            line_mem[victim_way][index] <= fill_line;
        end
    end

    assign bus.hit      = hit_reg;
    assign bus.data_out = data_reg;
endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench: each fetch pushes its expected {hit, word} to a queue,
// which is popped and compared one clock later against the registered outputs.
module tb_instruction_cache;
    logic clk;
    logic rst;

    instruction_cache_if bus ();

    instruction_cache dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        hit;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic        last_hit;
    logic [63:0] last_data;

    function automatic logic [63:0] bstore(input logic [31:0] a);
        logic [31:0] al;
        al = {a[31:3], 3'b000};
        return {al, ~al};
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one request on the falling edge; result is checked after the next rising edge.
    task automatic fetch(input logic [31:0] a, input logic exp_hit);
        exp_t e;
        @(negedge clk);
        bus.addr      = a;
        bus.fetch_req = 1'b1;
        e.addr = a;
        e.hit  = exp_hit;
        e.data = bstore(a);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        $display("fetch addr=%h hit=%0b data=%h", e.addr, bus.hit, bus.data_out);
        check($sformatf("hit@%h", e.addr), {63'b0, bus.hit}, {63'b0, e.hit});
        check($sformatf("data@%h", e.addr), bus.data_out, e.data);
        last_hit  = e.hit;
        last_data = e.data;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            bus.fetch_req = 1'b0;
            bus.addr      = $urandom;
            @(posedge clk);
            #1;
            $display("idle cycle=%0d hit=%0b data=%h", i, bus.hit, bus.data_out);
            check("idle_hit", {63'b0, bus.hit}, {63'b0, last_hit});
            check("idle_data", bus.data_out, last_data);
        end
    endtask

    initial begin
        rst           = 1'b0;
        bus.addr      = 32'h0;
        bus.fetch_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hit", {63'b0, bus.hit}, 64'h0);
        check("reset_data", bus.data_out, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        fetch(32'h0000_1000, 1'b0);
        check("first_word_const", bus.data_out, 64'h00001000_FFFFEFFF);
        fetch(32'h0000_1000, 1'b1);
        fetch(32'h0000_1008, 1'b1);
        check("second_word_const", bus.data_out, 64'h00001008_FFFFEFF7);
        fetch(32'h0000_1018, 1'b1);
        fetch(32'h0000_1007, 1'b1);
        fetch(32'h0000_2000, 1'b0);
        check("tag4_const", bus.data_out, 64'h00002000_FFFFDFFF);
        fetch(32'h0000_2000, 1'b1);
        fetch(32'h0000_3000, 1'b0);
        check("tag6_const", bus.data_out, 64'h00003000_FFFFCFFF);
        fetch(32'h0000_2000, 1'b1);
        fetch(32'h0000_1000, 1'b0);
        fetch(32'h0000_3000, 1'b0);
        fetch(32'h0000_1010, 1'b1);
        fetch(32'h0000_3018, 1'b1);

        // Other sets, including the last index.
        fetch(32'h0000_1FE0, 1'b0);
        for (int w = 0; w < 4; w++) fetch(32'h0000_1FE0 + 32'(w * 8), 1'b1);
        fetch(32'hABCD_E0A8, 1'b0);
        fetch(32'hABCD_E0B0, 1'b1);

        fetch(32'h0000_1000, 1'b1);
        idle(5);

        // Asynchronous reset between edges clears outputs immediately.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_hit", {63'b0, bus.hit}, 64'h0);
        check("async_rst_data", bus.data_out, 64'h0);
        @(negedge clk);
        bus.addr      = 32'h0000_2000;
        bus.fetch_req = 1'b1;
        @(posedge clk);
        #1;
        check("req_in_rst_hit", {63'b0, bus.hit}, 64'h0);
        check("req_in_rst_data", bus.data_out, 64'h0);
        @(negedge clk);
        bus.fetch_req = 1'b0;
        rst = 1'b1;

        fetch(32'h0000_1000, 1'b0);
        fetch(32'h0000_2000, 1'b0);
        fetch(32'h0000_1000, 1'b1);
        fetch(32'h0000_2008, 1'b1);

        @(negedge clk);
        bus.fetch_req = 1'b0;
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
